// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One shift-add (mul) or restoring shift-subtract (div) step per cycle over WIDTH cycles.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Shared datapath: upper half is product accumulator / partial remainder,
  // lower half is the multiplier / dividend being shifted out (quotient shifted in).
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand conditioning
  logic             op_muldiv, op_signed, op_div;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_abs, rt_abs;

  assign op_muldiv = ~op[2];
  assign op_div    = op[1];
  assign op_signed = ~op[0];
  assign rs_neg    = op_signed & rs_val[WIDTH-1];
  assign rt_neg    = op_signed & rt_val[WIDTH-1];
  assign rs_abs    = rs_neg ? (~rs_val + 1'b1) : rs_val;
  assign rt_abs    = rt_neg ? (~rt_val + 1'b1) : rt_val;

  // Single iteration step
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] p_mul;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [2*WIDTH-1:0] p_div;

  always_comb begin
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? opnd_q : {WIDTH{1'b0}})};
    p_mul    = {mul_sum, p_q[WIDTH-1:1]};
    rem_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
    // Bit WIDTH of the difference is the borrow: set means restore.
    if (!rem_diff[WIDTH])
      p_div = {rem_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    else
      p_div = {rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
  end

  // Sign fix-up of the finished result
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_mag, rem_mag, quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_res_q ? (~p_q + 1'b1) : p_q;
    quo_mag  = p_q[WIDTH-1:0];
    rem_mag  = p_q[2*WIDTH-1:WIDTH];
    quo_fix  = dz_q ? {WIDTH{1'b1}} : (neg_res_q ? (~quo_mag + 1'b1) : quo_mag);
    // With a zero divisor the remainder holds |rs|, so the dividend sign restores rs.
    rem_fix  = neg_rem_q ? (~rem_mag + 1'b1) : rem_mag;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          if (op_muldiv) begin
            state_d   = RUN;
            cnt_d     = '0;
            busy_d    = 1'b1;
            is_div_d  = op_div;
            neg_res_d = rs_neg ^ rt_neg;
            neg_rem_d = rs_neg;
            dz_d      = (rt_val == '0);
            opnd_d    = op_div ? rt_abs : rs_abs;
            p_d       = {{WIDTH{1'b0}}, (op_div ? rs_abs : rt_abs)};
          end else if (op == OP_MTHI) begin
            hi_d = rs_val;
          end else if (op == OP_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          p_d   = is_div_q ? p_div : p_mul;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST)
            state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      p_q       <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed self-checking bench for mips_muldiv_unit: mul/div results, timing,
// flush, ignored start, start+flush collision and async reset.
module tb_mips_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_fail = 0;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Issue one mul/div op and follow it to completion. A nonzero inj pulses
  // a MULT start on that busy cycle, which must be ignored.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input int inj);
    int n;
    int early;
    n = 0;
    early = 0;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (done !== 1'b0) early++;
      if (n == inj) begin
        start = 1'b1; op = 3'b000; rs_val = 32'd3; rt_val = 32'd4;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
    chk({tag, "_early_done"}, 64'(early), 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
    @(negedge clk);
    chk({tag, "_done_fall"}, {63'd0, done}, 64'd0);
  endtask

  task automatic mtxx(input logic [2:0] o, input logic [31:0] v, input logic fl);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = v; flush = fl;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
  endtask

  initial begin
    int dones;
    reset = 1'b0; start = 1'b0; op = 3'b0; rs_val = '0; rt_val = '0; flush = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'($urandom); op = 3'($urandom); rs_val = $urandom; rt_val = $urandom;
      flush = 1'($urandom);
      #1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_lo", {32'd0, lo}, 64'd0);
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0; op = 3'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);

    do_op("mult",  3'b000, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
    do_op("multu", 3'b001, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA, 0);
    do_op("div",   3'b010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    do_op("divu0", 3'b011, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF, 0);
    do_op("ovf",   3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
    do_op("div0s", 3'b010, 32'hFFFFFFF7, 32'h0, 32'hFFFFFFF7, 32'hFFFFFFFF, 0);
    do_op("multp", 3'b000, 32'h00012345, 32'hFFFF0000, 32'hFFFFFFFE, 32'hDCBB0000, 0);

    // MTHI single-edge latency, no busy/done
    mtxx(3'b100, 32'hCAFE0000, 1'b0);
    chk("mthi_hi", {32'd0, hi}, {32'd0, 32'hCAFE0000});
    chk("mthi_lo", {32'd0, lo}, {32'd0, 32'hDCBB0000});
    chk("mthi_busy", {63'd0, busy}, 64'd0);

    // Flush on cycle 10 of RUN
    @(negedge clk);
    start = 1'b1; op = 3'b000; rs_val = 32'd5; rt_val = 32'd6;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0) dones++;
      @(negedge clk);
    end
    chk("flush_no_done", 64'(dones), 64'd0);
    chk("flush_hi", {32'd0, hi}, {32'd0, 32'hCAFE0000});
    chk("flush_lo", {32'd0, lo}, {32'd0, 32'hDCBB0000});
    mtxx(3'b101, 32'h1234, 1'b0);
    chk("mtlo_lo", {32'd0, lo}, {32'd0, 32'h1234});
    chk("mtlo_hi", {32'd0, hi}, {32'd0, 32'hCAFE0000});

    // Start pulse mid-RUN ignored
    do_op("divu_inj", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 15);
    chk("inj_idle_busy", {63'd0, busy}, 64'd0);

    // start+flush in IDLE: nothing accepted
    mtxx(3'b100, 32'hDEADBEEF, 1'b1);
    chk("sf_mthi_hi", {32'd0, hi}, 64'd2);
    mtxx(3'b000, 32'd9, 1'b1);
    chk("sf_mult_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("sf_mult_busy2", {63'd0, busy}, 64'd0);
    chk("sf_lo", {32'd0, lo}, 64'd14);

    // Async reset between edges during RUN
    @(negedge clk);
    start = 1'b1; op = 3'b001; rs_val = 32'd11; rt_val = 32'd13;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("ar_pre_busy", {63'd0, busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_busy", {63'd0, busy}, 64'd0);
    chk("ar_hi", {32'd0, hi}, 64'd0);
    chk("ar_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) dones++;
      @(negedge clk);
    end
    chk("ar_no_done", 64'(dones), 64'd0);
    chk("ar_lo_after", {32'd0, lo}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the EX stage of the MIPS pipeline. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the EX stage and computes products and quotients over 32 iterations. While it works it raises `busy` so the hazard logic stalls any dependent MFHI/MFLO or new mul/div, and it presents HI/LO to the EX-stage result mux.

## Interface
- `WIDTH`, 32, operand and HI/LO width; iteration count equals `WIDTH`.
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `start`  in  1  EX stage issues an op this cycle.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- `rs_val`  in  WIDTH  forwarded rs operand (multiplicand / dividend / MTxx source).
- `rt_val`  in  WIDTH  forwarded rt operand (multiplier / divisor).
- `flush`  in  1  squash the in-flight op (branch/exception flush of EX).
- `busy`  out  1  registered; 1 while an iterative op is in progress.
- `done`  out  1  registered one-cycle pulse when HI/LO take a mul/div result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE, `start` & mul/div op & !`flush`:
  - latch operand magnitudes (absolute values for signed ops) and result-sign flags;
  - clear the iteration counter and go to RUN.
- IDLE, `start` & MTHI/MTLO & !`flush`: write `rs_val` to `hi`/`lo` at that edge and stay in IDLE. `busy` and `done` do not change.
- RUN: one shift-add step (multiply) or one restoring shift-subtract step (divide) per cycle. After WIDTH steps go to FINISH.
- FINISH:
  - apply the sign fix-up and write `hi`/`lo`;
  - pulse `done`, drop `busy`, return to IDLE.
- Multiply: the 2·WIDTH product goes to {hi, lo}. Signed results are the two's complement of the magnitude product when the operand signs differ.
- Divide: `lo` = quotient, `hi` = remainder, with truncation toward zero.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero: `hi` = `rs_val`, `lo` = all ones, for both signed and unsigned. It still takes the full latency.
- Signed overflow (-2^(W-1) / -1): `lo` = 0x80000000, `hi` = 0.
- `start` while `busy`=1 is ignored. The hazard unit guarantees it stalls instead, so no queuing is done here.
- `flush` in RUN or FINISH: return to IDLE at that edge. `hi`/`lo` are unchanged, there is no `done` pulse, and `busy`=0 the next cycle.
- `flush` with `start` in the same cycle: `flush` wins and nothing is accepted, including MTHI/MTLO.
- `reset` low at any time, including mid-operation: state IDLE, counter 0, `busy`=0, `done`=0, `hi`=0, `lo`=0.

## Timing
- Start sampled at edge N: `busy`=1 after edge N.
- RUN occupies edges N+1 … N+WIDTH.
- FINISH writes `hi`/`lo` at edge N+WIDTH+1. At that same edge `done` goes to 1 and `busy` goes to 0.
- `done` stays high for exactly one cycle and falls at edge N+WIDTH+2.
- `busy` is high for WIDTH+1 = 33 cycles. The result is readable by MFHI/MFLO in the cycle after the FINISH edge (while `done`=1).
- A new mul/div may be accepted in the same cycle `done`=1: back-to-back ops run with a 34-cycle issue interval.
- MTHI/MTLO have a single-edge latency.
- `busy` and `done` are flop outputs with no combinational path from the inputs. `hi`/`lo` are flop outputs.

## Test plan
- Reset: hold `reset`=0 with random inputs. Then `hi`=`lo`=0, `busy`=`done`=0, and they stay there until `reset` is released.
- MULT 0xFFFFFFFE × 0x00000003 (−2×3):
  - `busy` high for 33 cycles;
  - then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA, with a single `done` pulse.
  - Repeat as MULTU: `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV 0xFFFFFFF9 ÷ 0x00000002 (−7÷2) gives `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7÷0 gives `hi`=7, `lo`=0xFFFFFFFF. DIV 0x80000000 ÷ 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- Flush: start MULT 5×6, assert `flush` on cycle 10 of RUN. Then `busy`=0 next cycle, no `done`, and `hi`/`lo` keep their prior values. Then issue MTLO 0x1234, which gives `lo`=0x1234 one edge later.
- Ignored start and collision:
  - issue DIVU 100÷7, then pulse `start` with MULT mid-RUN: the result is still `lo`=14, `hi`=2;
  - `start`+`flush` in the same IDLE cycle leaves no state change.
- Async reset mid-op: drop `reset` between clock edges during RUN. `busy`, `hi`, `lo` clear immediately without waiting for an edge, and no `done` pulse occurs after release.
